// File: rtl/bm_match_pkg.sv
// Shared definitions for the multiply-add / divide microbenchmark blocks.
// Default widths, FSM encoding and the iteration counter width helper.
package bm_match_pkg;

    localparam int BITS0_DEF = 9;
    localparam int BITS2_DEF = 18;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Counter must reach BITS2 itself: the cycle after the last iteration latches results.
    function automatic int cnt_width(input int bits2);
        return $clog2(bits2 + 1);
    endfunction

endpackage

// File: rtl/bm_div_step.sv
// One radix-2 restoring division stage: shift in a dividend bit, subtract the divisor if it fits.
module bm_div_step #(
    parameter int BITS0 = 9
) (
    input  logic [BITS0-1:0] part_rem,
    input  logic             dvd_bit,
    input  logic [BITS0-1:0] divisor,
    output logic [BITS0-1:0] next_rem,
    output logic             q_bit
);

    logic [BITS0:0] partial;
    logic [BITS0:0] diff;

    always_comb begin
        partial  = {part_rem, dvd_bit};
        diff     = partial - {1'b0, divisor};
        q_bit    = (partial >= {1'b0, divisor});
        // Both candidates are below 2^BITS0, so dropping the top bit is lossless.
        next_rem = q_bit ? diff[BITS0-1:0] : partial[BITS0-1:0];
    end

endmodule

// File: rtl/bm_divmod_seq.sv
// Sequential unsigned divider, one quotient bit per clock, start/busy/done handshake.
// Results are registered on entry to DONE and held until the next accepted start.
module bm_divmod_seq
    import bm_match_pkg::*;
#(
    parameter int BITS0 = BITS0_DEF,
    parameter int BITS2 = BITS2_DEF
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic [BITS2-1:0] dividend,
    input  logic [BITS0-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [BITS2-1:0] quotient,
    output logic [BITS0-1:0] remainder,
    output logic             div_by_zero
);

    localparam int CNT_W = cnt_width(BITS2);

    state_t state;
    state_t next_state;

    logic [BITS0-1:0] div_r;
    logic [BITS0-1:0] rem_r;
    logic [BITS2-1:0] dvd_r;
    logic [BITS2-1:0] quo_r;
    logic [CNT_W-1:0] cnt;
    logic             dz_r;

    logic [BITS0-1:0] step_rem;
    logic             step_q;
    logic             accept;
    logic             finish;

    bm_div_step #(.BITS0(BITS0)) u_step (
        .part_rem (rem_r),
        .dvd_bit  (dvd_r[BITS2-1]),
        .divisor  (div_r),
        .next_rem (step_rem),
        .q_bit    (step_q)
    );

    assign accept = (state != RUN) && start;
    // A zero divisor skips the iterations but still spends one RUN cycle latching results.
    assign finish = (state == RUN) && (dz_r || (cnt == CNT_W'(BITS2)));

    always_ff @(posedge clock) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        busy       = 1'b0;
        done       = 1'b0;
        case (state)
            IDLE: begin
                if (start) next_state = RUN;
            end
            RUN: begin
                busy = 1'b1;
                if (finish) next_state = DONE;
            end
            DONE: begin
                done       = 1'b1;
                next_state = start ? RUN : IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            div_r       <= '0;
            rem_r       <= '0;
            dvd_r       <= '0;
            quo_r       <= '0;
            cnt         <= '0;
            dz_r        <= 1'b0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
        end else if (accept) begin
            div_r <= divisor;
            dvd_r <= dividend;
            rem_r <= '0;
            quo_r <= '0;
            cnt   <= '0;
            dz_r  <= (divisor == '0);
        end else if (state == RUN) begin
            if (finish) begin
                quotient    <= dz_r ? '1 : quo_r;
                remainder   <= dz_r ? '0 : rem_r;
                div_by_zero <= dz_r;
            end else begin
                rem_r <= step_rem;
                dvd_r <= dvd_r << 1;
                quo_r <= {quo_r[BITS2-2:0], step_q};
                cnt   <= cnt + CNT_W'(1);
            end
        end
    end

endmodule
